// File: rtl/image_cmd_engine.sv
// Pixel-store command engine: decodes host command/data strobes into streamed RAM access
// and whole-image point-operation passes over a single-port synchronous-read RAM.
//
// state  | meaning
// IDLE   | accepting commands and data strobes
// P_RD   | RAM address driven with idx, pixel read in flight
// P_WR   | f(pixel) written back to mem[idx]
// P_DONE | DONE_BYTE presented, ptr/mode cleared
module image_cmd_engine #(
   parameter int         ADDR_W    = 10,
   parameter logic [7:0] DONE_BYTE = 8'h55
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ip_comm_cmd,
   input  logic       ip_comm_cmd_valid,
   input  logic [7:0] ip_comm_data_in,
   input  logic       ip_comm_data_in_valid,
   output logic [7:0] ip_comm_data_out,
   output logic       ip_comm_data_out_valid,
   output logic       busy
);
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {M_NOP, M_WRITE, M_READ, M_ARG_THR, M_ARG_ADD} mode_t;
   typedef enum logic [1:0] {OP_INV, OP_THR, OP_ADD} op_t;
   typedef enum logic [1:0] {IDLE, P_RD, P_WR, P_DONE} state_t;

   logic [7:0]        mem [2**ADDR_W];
   logic [7:0]        ram_q, ram_wdata, pix_f, arg;
   logic [8:0]        sum;
   logic [ADDR_W-1:0] ram_addr, ptr, idx;
   logic              ram_we, rd_s1;
   logic              cmd_fire, data_fire, wr_fire, rd_fire, arg_fire;
   mode_t             mode;
   op_t               op;
   state_t            state;

   // A command in the same cycle as a data byte wins; the byte is discarded.
   assign cmd_fire  = ip_comm_cmd_valid && !busy;
   assign data_fire = ip_comm_data_in_valid && !ip_comm_cmd_valid && !busy;
   assign wr_fire   = data_fire && (mode == M_WRITE);
   assign rd_fire   = data_fire && (mode == M_READ);
   assign arg_fire  = data_fire && ((mode == M_ARG_THR) || (mode == M_ARG_ADD));

   always_comb begin
      sum   = {1'b0, ram_q} + {1'b0, arg};
      pix_f = ~ram_q;
      case (op)
         OP_THR:  pix_f = (ram_q >= arg) ? 8'hFF : 8'h00;
         OP_ADD:  pix_f = sum[8] ? 8'hFF : sum[7:0];
         default: pix_f = ~ram_q;
      endcase
   end

   // Write enable is gated by reset so an aborted pass never commits its current pixel.
   always_comb begin
      ram_addr  = ptr;
      ram_we    = 1'b0;
      ram_wdata = ip_comm_data_in;
      if ((state == P_RD) || (state == P_WR)) begin
         ram_addr  = idx;
         ram_we    = (state == P_WR) && rst_n;
         ram_wdata = pix_f;
      end else if (wr_fire) begin
         ram_we = rst_n;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ip_comm_data_out       <= 8'h00;
         ip_comm_data_out_valid <= 1'b0;
         busy                   <= 1'b0;
         ptr                    <= '0;
         idx                    <= '0;
         arg                    <= 8'h00;
         mode                   <= M_NOP;
         op                     <= OP_INV;
         state                  <= IDLE;
         rd_s1                  <= 1'b0;
      end else begin
         ip_comm_data_out_valid <= 1'b0;
         rd_s1                  <= rd_fire;
         if (rd_s1) begin
            ip_comm_data_out       <= ram_q;
            ip_comm_data_out_valid <= 1'b1;
         end
         if (wr_fire || rd_fire) ptr <= ptr + ONE;

         if (cmd_fire) begin
            case (ip_comm_cmd)
               8'h00: mode <= M_NOP;
               8'h01: begin
                  ptr  <= '0;
                  mode <= M_NOP;
               end
               8'h02: mode <= M_WRITE;
               8'h03: mode <= M_READ;
               8'h04: begin
                  op    <= OP_INV;
                  mode  <= M_NOP;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= P_RD;
               end
               8'h05: mode <= M_ARG_THR;
               8'h06: mode <= M_ARG_ADD;
               default: mode <= M_NOP;
            endcase
         end

         if (arg_fire) begin
            arg   <= ip_comm_data_in;
            op    <= (mode == M_ARG_THR) ? OP_THR : OP_ADD;
            idx   <= '0;
            busy  <= 1'b1;
            state <= P_RD;
         end

         case (state)
            P_RD: state <= P_WR;
            P_WR: begin
               if (idx == LAST_IDX) begin
                  ip_comm_data_out       <= DONE_BYTE;
                  ip_comm_data_out_valid <= 1'b1;
                  state                  <= P_DONE;
               end else begin
                  idx   <= idx + ONE;
                  state <= P_RD;
               end
            end
            P_DONE: begin
               ptr   <= '0;
               mode  <= M_NOP;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_image_cmd_engine.sv
// Scoreboard bench for image_cmd_engine: an array-based model predicts every returned byte
// and its cycle; a negedge monitor pops and compares whatever the DUT presents.
module tb_image_cmd_engine;
   localparam int AW = 4;
   localparam int N  = 1 << AW;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ip_comm_cmd;
   logic       ip_comm_cmd_valid;
   logic [7:0] ip_comm_data_in;
   logic       ip_comm_data_in_valid;
   logic [7:0] ip_comm_data_out;
   logic       ip_comm_data_out_valid;
   logic       busy;

   image_cmd_engine #(.ADDR_W(AW), .DONE_BYTE(8'h55)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .ip_comm_cmd            (ip_comm_cmd),
      .ip_comm_cmd_valid      (ip_comm_cmd_valid),
      .ip_comm_data_in        (ip_comm_data_in),
      .ip_comm_data_in_valid  (ip_comm_data_in_valid),
      .ip_comm_data_out       (ip_comm_data_out),
      .ip_comm_data_out_valid (ip_comm_data_out_valid),
      .busy                   (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      bit         care;
      int         cyc;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state: modes 0=NOP 1=WRITE 2=READ 3=THR-arg 4=ADD-arg
   int mem_m[N];
   bit known[N];
   int pre_mem[N];
   bit pre_known[N];
   int ptr_m, mode_m, busy_end, pass_t0;

   function automatic int pix_op(int op, int a, int p);
      case (op)
         0:       return 255 - p;
         1:       return (p >= a) ? 255 : 0;
         default: return (p + a > 255) ? 255 : p + a;
      endcase
   endfunction

   function automatic void start_pass(int op, int a, int t);
      for (int i = 0; i < N; i++) begin
         pre_mem[i]   = mem_m[i];
         pre_known[i] = known[i];
         mem_m[i]     = pix_op(op, a, mem_m[i]);
      end
      expq.push_back('{8'h55, 1'b1, t + 1 + 2 * N});
      busy_end = t + 2 + 2 * N;
      pass_t0  = t;
      ptr_m    = 0;
      mode_m   = 0;
   endfunction

   function automatic void model_step(bit cv, logic [7:0] c, bit dv, logic [7:0] d, int t);
      if (t < busy_end) return;
      if (cv) begin
         case (c)
            8'h00: mode_m = 0;
            8'h01: begin ptr_m = 0; mode_m = 0; end
            8'h02: mode_m = 1;
            8'h03: mode_m = 2;
            8'h04: start_pass(0, 0, t);
            8'h05: mode_m = 3;
            8'h06: mode_m = 4;
            default: mode_m = 0;
         endcase
      end else if (dv) begin
         case (mode_m)
            1: begin
               mem_m[ptr_m] = int'(d);
               known[ptr_m] = 1'b1;
               ptr_m = (ptr_m + 1) % N;
            end
            2: begin
               expq.push_back('{8'(mem_m[ptr_m]), known[ptr_m], t + 2});
               ptr_m = (ptr_m + 1) % N;
            end
            3: start_pass(1, int'(d), t);
            4: start_pass(2, int'(d), t);
            default: ;
         endcase
      end
   endfunction

   // Pixel i is written in cycle pass_t0+2+2i; pixels at the abort boundary are left unjudged.
   function automatic void model_abort(int r);
      if (r < busy_end) begin
         for (int i = 0; i < N; i++) begin
            if (pass_t0 + 2 + 2 * i < r) begin
            end else if (pass_t0 + 1 + 2 * i > r) begin
               mem_m[i] = pre_mem[i];
               known[i] = pre_known[i];
            end else begin
               known[i] = 1'b0;
            end
         end
      end
      busy_end = 0;
      ptr_m    = 0;
      mode_m   = 0;
      expq.delete();
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_out: no strobe for byte %0h due at cycle %0d", e.data, e.cyc);
         end
         if (ip_comm_data_out_valid === 1'b1) begin
            n_checks++;
            if (expq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: byte %0h at cycle %0d, required no strobe",
                        ip_comm_data_out, cyc);
            end else begin
               e = expq.pop_front();
               if (e.cyc != cyc || (e.care && ip_comm_data_out !== e.data)) begin
                  n_fail++;
                  $display("FAIL out_byte: got %0h at cycle %0d, required %0h at cycle %0d",
                           ip_comm_data_out, cyc, e.data, e.cyc);
               end
            end
         end
      end
   end

   task automatic send(bit cv, logic [7:0] c, bit dv, logic [7:0] d);
      ip_comm_cmd_valid     = cv;
      ip_comm_cmd           = c;
      ip_comm_data_in_valid = dv;
      ip_comm_data_in       = d;
      model_step(cv, c, dv, d, cyc);
      @(posedge clk);
      #1;
      ip_comm_cmd_valid     = 1'b0;
      ip_comm_data_in_valid = 1'b0;
   endtask

   task automatic cmd(logic [7:0] c);
      send(1'b1, c, 1'b0, 8'h00);
   endtask

   task automatic dat(logic [7:0] d);
      send(1'b0, 8'h00, 1'b1, d);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_abort(cyc);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out", 32'(ip_comm_data_out), 32'd0);
      check("rst_out_valid", 32'(ip_comm_data_out_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         mem_m[i] = 0;
         known[i] = 1'b0;
      end
      ptr_m = 0; mode_m = 0; busy_end = 0; pass_t0 = 0;
      rst_n = 1'b0;
      ip_comm_cmd = 8'h00; ip_comm_cmd_valid = 1'b0;
      ip_comm_data_in = 8'h00; ip_comm_data_in_valid = 1'b0;
      idle(3);
      check("reset_out", 32'(ip_comm_data_out), 32'd0);
      check("reset_out_valid", 32'(ip_comm_data_out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      idle(1);

      // basic write then pipelined read-back
      cmd(8'h01); cmd(8'h02);
      dat(8'h10); dat(8'h20); dat(8'h30);
      cmd(8'h01); cmd(8'h03);
      dat(8'h00); dat(8'hEE); dat(8'h5A);
      idle(4);

      // pointer wrap: 17 writes, read continues at index 1, then index 0
      cmd(8'h01); cmd(8'h02);
      for (int i = 0; i <= N; i++) dat(8'(i));
      cmd(8'h03); dat(8'h00);
      cmd(8'h01); cmd(8'h03); dat(8'h00);
      idle(4);

      // invert pass with exact busy window
      cmd(8'h01); cmd(8'h02);
      dat(8'h00); dat(8'h7F); dat(8'h80); dat(8'hFF);
      cmd(8'h04);
      check("pass_busy_start", 32'(busy), 32'd1);
      idle(2 * N - 1);
      check("pass_busy_last", 32'(busy), 32'd1);
      check("pass_no_early_done", 32'(ip_comm_data_out_valid), 32'd0);
      idle(1);
      check("pass_done_valid", 32'(ip_comm_data_out_valid), 32'd1);
      check("pass_done_byte", 32'(ip_comm_data_out), 32'h55);
      check("pass_busy_in_done", 32'(busy), 32'd1);
      idle(1);
      check("pass_busy_end", 32'(busy), 32'd0);
      cmd(8'h03);
      repeat (4) dat(8'h00);
      idle(4);

      // threshold and saturating add
      cmd(8'h01); cmd(8'h02); dat(8'h7F); dat(8'h80);
      cmd(8'h05); dat(8'h80);
      idle(2 * N + 2);
      cmd(8'h03); dat(8'h00); dat(8'h00);
      cmd(8'h01); cmd(8'h02); dat(8'h60); dat(8'h80);
      cmd(8'h06); dat(8'h90);
      idle(2 * N + 2);
      cmd(8'h03); dat(8'h00); dat(8'h00);
      idle(4);

      // strobes during a pass are dropped; mode is NOP afterwards
      cmd(8'h04);
      cmd(8'h03); dat(8'h11); dat(8'h22);
      cmd(8'h02); dat(8'h33);
      idle(2 * N);
      dat(8'h44); dat(8'h45);
      idle(4);

      // simultaneous CLR_PTR and data in WRITE mode: command wins, no write
      cmd(8'h01); cmd(8'h02); dat(8'hAA);
      send(1'b1, 8'h01, 1'b1, 8'h33);
      dat(8'hBB);
      cmd(8'h01); cmd(8'h03); dat(8'h00); dat(8'h00); dat(8'h00);
      idle(4);

      // reset in the middle of a pass
      cmd(8'h01); cmd(8'h02);
      for (int i = 0; i < N; i++) dat(8'($urandom));
      cmd(8'h04);
      idle(12);
      pulse_reset();
      cmd(8'h03);
      for (int i = 0; i < N; i++) dat(8'h00);
      idle(4);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         int k;
         k = int'($urandom_range(0, 19));
         if (k < 3)        cmd(8'($urandom_range(0, 7)));
         else if (k < 4)   cmd(8'($urandom));
         else if (k < 14)  dat(8'($urandom));
         else if (k < 15)  send(1'b1, 8'($urandom_range(0, 6)), 1'b1, 8'($urandom));
         else              idle(1);
      end
      idle(2 * N + 8);
      check("queue_drained", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
